// File: rtl/mem_arbiter_if.sv
// Bundle of the IF/MEM request ports and the SRAM pin group seen by mem_arbiter.
// slave is the arbiter's view; master is the pipeline/board side.
interface mem_arbiter_if;
  logic        if_req;
  logic [15:0] if_addr;
  logic [15:0] if_rdata;
  logic        if_ready;
  logic [1:0]  mem_op;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ready;
  logic        stall;
  logic [15:0] ram_addr;
  logic [15:0] ram_dq_o;
  logic        ram_dq_oe;
  logic [15:0] ram_dq_i;
  logic        ram_oe_n;
  logic        ram_we_n;
  logic        ram_ce_n;

  modport slave (
    input  if_req, if_addr, mem_op, mem_addr, mem_wdata, ram_dq_i,
    output if_rdata, if_ready, mem_rdata, mem_ready, stall,
           ram_addr, ram_dq_o, ram_dq_oe, ram_oe_n, ram_we_n, ram_ce_n
  );

  modport master (
    output if_req, if_addr, mem_op, mem_addr, mem_wdata, ram_dq_i,
    input  if_rdata, if_ready, mem_rdata, mem_ready, stall,
           ram_addr, ram_dq_o, ram_dq_oe, ram_oe_n, ram_we_n, ram_ce_n
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one 16-bit async SRAM between instruction fetch and load/store,
// sequencing the read and write pin waveforms and stalling the pipeline meanwhile.
module mem_arbiter #(
  parameter int READ_WAIT = 1
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_WS   = 3'd2;
  localparam logic [2:0] S_WP   = 3'd3;
  localparam logic [2:0] S_WH   = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  localparam logic       REQ_IF  = 1'b0;
  localparam logic       REQ_MEM = 1'b1;
  localparam logic [2:0] RD_LAST = 3'(READ_WAIT - 1);

  logic [2:0]  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        who_q, who_d;
  logic        last_q, last_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] if_rdata_q, if_rdata_d;
  logic [15:0] mem_rdata_q, mem_rdata_d;

  logic mem_rd, mem_wr, mem_pend, grant_mem;

  assign mem_rd   = (bus.mem_op == 2'b01);
  assign mem_wr   = (bus.mem_op == 2'b10);
  assign mem_pend = mem_rd | mem_wr;
  // Under contention MEM normally wins; IF gets the next slot right after a MEM grant.
  assign grant_mem = mem_pend && (!bus.if_req || last_q != REQ_MEM);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    who_d       = who_q;
    last_d      = last_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (grant_mem) begin
          who_d   = REQ_MEM;
          last_d  = REQ_MEM;
          addr_d  = bus.mem_addr;
          wdata_d = bus.mem_wdata;
          cnt_d   = 3'd0;
          state_d = mem_wr ? S_WS : S_RD;
        end else if (bus.if_req) begin
          who_d   = REQ_IF;
          last_d  = REQ_IF;
          addr_d  = bus.if_addr;
          cnt_d   = 3'd0;
          state_d = S_RD;
        end
      end
      S_RD: begin
        if (cnt_q == RD_LAST) begin
          cnt_d   = 3'd0;
          state_d = S_DONE;
          if (who_q == REQ_MEM) mem_rdata_d = bus.ram_dq_i;
          else                  if_rdata_d  = bus.ram_dq_i;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_WS:    state_d = S_WP;
      S_WP:    state_d = S_WH;
      S_WH:    state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 3'd0;
      who_q       <= REQ_IF;
      last_q      <= REQ_IF;
      addr_q      <= 16'h0000;
      wdata_q     <= 16'h0000;
      if_rdata_q  <= 16'h0000;
      mem_rdata_q <= 16'h0000;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      who_q       <= who_d;
      last_q      <= last_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  // Pins decode straight from the state register, so reset forces them idle on the same edge.
  assign bus.ram_ce_n  = !(state_q == S_RD || state_q == S_WS ||
                           state_q == S_WP || state_q == S_WH);
  assign bus.ram_oe_n  = (state_q != S_RD);
  assign bus.ram_we_n  = (state_q != S_WP);
  assign bus.ram_dq_oe = (state_q == S_WS || state_q == S_WP || state_q == S_WH);
  assign bus.ram_addr  = addr_q;
  assign bus.ram_dq_o  = wdata_q;

  assign bus.if_ready  = (state_q == S_DONE) && (who_q == REQ_IF);
  assign bus.mem_ready = (state_q == S_DONE) && (who_q == REQ_MEM);
  assign bus.if_rdata  = if_rdata_q;
  assign bus.mem_rdata = mem_rdata_q;

  assign bus.stall = (mem_pend && !bus.mem_ready) || (bus.if_req && !bus.if_ready);

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbiter and sequencer for the single shared 16-bit SRAM in the ThinPad pipeline. It multiplexes instruction fetch (IF) and load/store (MEM) requests onto one SRAM port and runs the multi-cycle SRAM read and write waveforms. It raises a pipeline stall while any request is outstanding. It sits between the IF/MEM stages and the board SRAM pins; MEM uses the same 2-bit operation encoding the decoder emits on controlMem.

## Interface
- READ_WAIT, default 1: cycles with ram_oe_n low before read data is captured; range 1..7.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  IF wants an instruction word.
- if_addr  in  16  IF word address.
- if_rdata  out  16  fetched word; valid only while if_ready=1.
- if_ready  out  1  one-cycle completion pulse for IF.
- mem_op  in  2  01 = read, 10 = write, 11/00 = none.
- mem_addr  in  16  MEM word address.
- mem_wdata  in  16  store data.
- mem_rdata  out  16  load data; valid only while mem_ready=1.
- mem_ready  out  1  one-cycle completion pulse for MEM.
- stall  out  1  pipeline hold request.
- ram_addr  out  16  SRAM address.
- ram_dq_o  out  16  SRAM write data.
- ram_dq_oe  out  1  1 = drive ram_dq_o onto the pad.
- ram_dq_i  in  16  SRAM pad read data.
- ram_oe_n  out  1  SRAM output enable, active-low.
- ram_we_n  out  1  SRAM write enable, active-low.
- ram_ce_n  out  1  SRAM chip enable, active-low.

## Operation
- States: IDLE, RD, WS (write setup), WP (write pulse), WH (write hold), DONE.
- Grant happens only in IDLE. On the granting edge, latch the op, addr, wdata and requester ID (last_grant).
- Arbitration when both requests are pending:
  - MEM wins, except when last_grant = MEM; then IF wins.
  - last_grant resets to IF.
- A single pending request is always granted.
- Transitions:
  - IDLE goes to RD on a read grant (IF, or mem_op=01) and to WS on a write grant (mem_op=10). With no request it stays in IDLE.
  - RD holds for READ_WAIT cycles, counted by a 3-bit counter. On the last RD edge, ram_dq_i is registered into the requester's rdata register; next state is DONE.
  - WS → WP → WH → DONE, one cycle each.
  - DONE → IDLE unconditionally.
- SRAM pins, per state:
  - ram_ce_n = 0 in RD, WS, WP and WH; 1 otherwise.
  - ram_oe_n = 0 only in RD.
  - ram_we_n = 0 only in WP.
  - ram_dq_oe = 1 in WS, WP and WH.
  - ram_addr and ram_dq_o come from the latched values and are stable for the whole access.
- if_ready or mem_ready is 1 only in DONE, selected by the latched requester ID. rdata registers hold their value until overwritten.
- stall = ((mem_op==01 or mem_op==10) and !mem_ready) or (if_req and !if_ready). It is combinational from the inputs and the state.
- Requester inputs may change mid-access; they are ignored until the next IDLE grant.

## Timing
- All outputs reset to: state IDLE, ready pulses 0, rdata 0, ram_ce_n/oe_n/we_n = 1, ram_dq_oe = 0, ram_addr 0, counter 0.
- Read: request present in cycle 0 → RD in cycles 1..READ_WAIT → ready in cycle READ_WAIT+1. Default latency is 2 cycles.
- Write: request in cycle 0 → WS in cycle 1, WP in cycle 2, WH in cycle 3 → mem_ready in cycle 4.
- Back-to-back: the earliest next grant is at the end of the IDLE cycle after DONE, so there is one idle bus cycle between accesses.
- A requester must drop or change its request on the edge that ends its ready cycle; otherwise it is serviced again.
- rst asserted in any state: on that edge, go to IDLE with all outputs at reset values. A write in WP is aborted with ram_we_n forced to 1 on the same edge. No ready pulse is issued for the aborted access.
- rst has priority over grant in the same cycle.

## Test plan
- IF read only, READ_WAIT=1:
  - stimulus: SRAM model returns 0x1234 at address 0x0040.
  - response: ram_oe_n low in cycle 1 only; if_ready=1 with if_rdata=0x1234 in cycle 2; stall=1 in cycles 0–1 and 0 in cycle 2.
- MEM write:
  - stimulus: addr 0x8000, data 0xBEEF.
  - response: ram_we_n low only in cycle 2; ram_dq_oe=1 in cycles 1–3; mem_ready in cycle 4; model memory holds 0xBEEF.
- Contention:
  - stimulus: if_req and mem_op=01 held continuously from reset.
  - response: grant order MEM, IF, MEM, IF; ready pulses in cycles 2, 5, 8, 11.
- Reset during WP:
  - stimulus: rst pulsed in cycle 2 of a write.
  - response: ram_we_n=1 and ram_ce_n=1 from the next cycle; no mem_ready; state IDLE.
- READ_WAIT=3:
  - stimulus: MEM read of 0x00FF returning 0x5A5A.
  - response: ram_oe_n low in cycles 1–3; mem_rdata=0x5A5A with mem_ready in cycle 4.
- Request change mid-access:
  - stimulus: mem_addr changed in cycle 1 of a read.
  - response: ram_addr keeps the originally latched address through DONE.
